// File: rtl/cordic_arbiter.sv
// cordic_arbiter: shares one CORDIC core among NUM_REQ requesters.
// Round-robin grant in IDLE, one operation in flight at a time, a watchdog
// turns a silent core into an error response, and the result is held
// until the consumer accepts it.
module cordic_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int POINT_WIDTH = 16,
    parameter int ANGLE_WIDTH = 16,
    parameter int TIMEOUT     = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*POINT_WIDTH-1:0] req_x,
    input  logic [NUM_REQ*POINT_WIDTH-1:0] req_y,
    input  logic [NUM_REQ*ANGLE_WIDTH-1:0] req_z,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]     rsp_id,
    output logic [POINT_WIDTH-1:0]         rsp_x,
    output logic [POINT_WIDTH-1:0]         rsp_y,
    output logic [ANGLE_WIDTH-1:0]         rsp_z,
    output logic                           rsp_err,
    output logic                           cor_start,
    output logic [POINT_WIDTH-1:0]         cor_x,
    output logic [POINT_WIDTH-1:0]         cor_y,
    output logic [ANGLE_WIDTH-1:0]         cor_z,
    input  logic [POINT_WIDTH-1:0]         cor_x_out,
    input  logic [POINT_WIDTH-1:0]         cor_y_out,
    input  logic [ANGLE_WIDTH-1:0]         cor_z_out,
    input  logic                           cor_done,
    output logic                           busy
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [ID_W-1:0]        rr_ptr;
    logic [CNT_W-1:0]       wait_cnt;
    logic [POINT_WIDTH-1:0] op_x;
    logic [POINT_WIDTH-1:0] op_y;
    logic [ANGLE_WIDTH-1:0] op_z;

    logic [ID_W-1:0]        grant;
    logic                   grant_found;
    int                     slot;
    logic                   timeout_hit;

    // The last counted WAIT cycle: the counter would step to TIMEOUT-1 here,
    // so the error response appears TIMEOUT cycles after cor_start.
    assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT - 2));

    // Round-robin search: walk offsets from high to low so the lowest offset
    // from rr_ptr that is requesting ends up as the winner.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        grant       = '0;
        grant_found = 1'b0;
        slot        = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            slot = (int'(rr_ptr) + k) % NUM_REQ;
            if (req_valid[slot]) begin
                grant       = ID_W'(slot);
                grant_found = 1'b1;
            end
        end
    end

    // Next-state logic; cor_done only matters while waiting, and it wins
    // over a timeout that lands in the same cycle.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (grant_found) state_next = S_ISSUE;
            S_ISSUE: state_next = S_WAIT;
            S_WAIT:  if (cor_done || timeout_hit) state_next = S_RESP;
            S_RESP:  if (rsp_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Datapath: operand capture, watchdog counter, result capture, pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: operand and result registers are reset as well, because
            // they drive cor_* and rsp_* ports that must read zero after reset.
            rr_ptr   <= '0;
            wait_cnt <= '0;
            op_x     <= '0;
            op_y     <= '0;
            op_z     <= '0;
            rsp_id   <= '0;
            rsp_x    <= '0;
            rsp_y    <= '0;
            rsp_z    <= '0;
            rsp_err  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_found) begin
                        rsp_id <= grant;
                        op_x   <= req_x[grant*POINT_WIDTH +: POINT_WIDTH];
                        op_y   <= req_y[grant*POINT_WIDTH +: POINT_WIDTH];
                        op_z   <= req_z[grant*ANGLE_WIDTH +: ANGLE_WIDTH];
                    end
                end
                S_ISSUE: wait_cnt <= '0;
                S_WAIT: begin
                    if (cor_done) begin
                        rsp_x   <= cor_x_out;
                        rsp_y   <= cor_y_out;
                        rsp_z   <= cor_z_out;
                        rsp_err <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                        if (timeout_hit) begin
                            rsp_x   <= '0;
                            rsp_y   <= '0;
                            rsp_z   <= '0;
                            rsp_err <= 1'b1;
                        end
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rr_ptr <= (rsp_id == ID_W'(NUM_REQ - 1)) ? '0 : rsp_id + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Port decode from the current state.
    always_comb begin
        req_ready = '0;
        if (!rst && state == S_IDLE && grant_found) req_ready[grant] = 1'b1;
    end

    assign busy      = (state != S_IDLE);
    assign cor_start = (state == S_ISSUE);
    assign rsp_valid = (state == S_RESP);
    assign cor_x     = (state == S_ISSUE || state == S_WAIT) ? op_x : '0;
    assign cor_y     = (state == S_ISSUE || state == S_WAIT) ? op_y : '0;
    assign cor_z     = (state == S_ISSUE || state == S_WAIT) ? op_z : '0;

endmodule

// File: tb/tb_cordic_arbiter.sv
// tb_cordic_arbiter: randomized transactions against a transaction-level
// model (round-robin pick, scheduled core completion, watchdog deadline).
module tb_cordic_arbiter;

    localparam int N  = 4;
    localparam int PW = 16;
    localparam int AW = 16;
    localparam int TO = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*PW-1:0] req_x;
    logic [N*PW-1:0] req_y;
    logic [N*AW-1:0] req_z;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [1:0]      rsp_id;
    logic [PW-1:0]   rsp_x;
    logic [PW-1:0]   rsp_y;
    logic [AW-1:0]   rsp_z;
    logic            rsp_err;
    logic            cor_start;
    logic [PW-1:0]   cor_x;
    logic [PW-1:0]   cor_y;
    logic [AW-1:0]   cor_z;
    logic [PW-1:0]   cor_x_out;
    logic [PW-1:0]   cor_y_out;
    logic [AW-1:0]   cor_z_out;
    logic            cor_done;
    logic            busy;

    int vectors     = 0;
    int miscompares = 0;
    int exp_ptr     = 0;

    cordic_arbiter #(
        .NUM_REQ(N), .POINT_WIDTH(PW), .ANGLE_WIDTH(AW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_z(req_z),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_z(rsp_z), .rsp_err(rsp_err),
        .cor_start(cor_start), .cor_x(cor_x), .cor_y(cor_y), .cor_z(cor_z),
        .cor_x_out(cor_x_out), .cor_y_out(cor_y_out), .cor_z_out(cor_z_out),
        .cor_done(cor_done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Round robin: first requesting index at or after ptr, modulo N.
    function automatic int model_grant(input logic [N-1:0] m, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (m[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic randomize_ops();
        for (int i = 0; i < N; i++) begin
            req_x[i*PW +: PW] = PW'($urandom);
            req_y[i*PW +: PW] = PW'($urandom);
            req_z[i*AW +: AW] = AW'($urandom);
        end
    endtask

    task automatic noise_core();
        cor_done  = 1'($urandom_range(0, 1));
        cor_x_out = PW'($urandom);
        cor_y_out = PW'($urandom);
        cor_z_out = AW'($urandom);
    endtask

    // One full transaction. delay = WAIT cycle index at which the core
    // reports done (-1: never). bp = cycles of rsp_ready=0 before accepting.
    task automatic run_txn(input logic [N-1:0] mask, input int delay, input int bp,
                           input logic [PW-1:0] dx, input logic [PW-1:0] dy,
                           input logic [AW-1:0] dz);
        int            g;
        logic [PW-1:0] ex, ey, rx, ry;
        logic [AW-1:0] ez, rz;
        logic          er;
        rx = '0; ry = '0; rz = '0; er = 1'b0;

        // Accept cycle: core noise and rsp_ready must be ignored here.
        @(posedge clk); #1;
        req_valid = mask;
        noise_core();
        rsp_ready = 1'($urandom_range(0, 1));
        g  = model_grant(mask, exp_ptr);
        ex = req_x[g*PW +: PW];
        ey = req_y[g*PW +: PW];
        ez = req_z[g*AW +: AW];
        @(negedge clk);
        check("accept_ready", req_ready, 64'(1) << g);
        check("accept_busy", busy, 0);
        check("accept_rsp_valid", rsp_valid, 0);
        check("accept_cor_start", cor_start, 0);

        // Issue cycle: other requesters keep asking and must be refused.
        @(posedge clk); #1;
        req_valid = mask & ~(N'(1) << g);
        noise_core();
        @(negedge clk);
        check("issue_cor_start", cor_start, 1);
        check("issue_cor_x", cor_x, ex);
        check("issue_cor_y", cor_y, ey);
        check("issue_cor_z", cor_z, ez);
        check("issue_ready", req_ready, 0);
        check("issue_busy", busy, 1);

        // Wait phase, bounded by the watchdog deadline.
        for (int w = 0; w <= TO - 2; w++) begin
            @(posedge clk); #1;
            cor_done  = (w == delay);
            cor_x_out = (w == delay) ? dx : PW'($urandom);
            cor_y_out = (w == delay) ? dy : PW'($urandom);
            cor_z_out = (w == delay) ? dz : AW'($urandom);
            @(negedge clk);
            check("wait_cor_start", cor_start, 0);
            check("wait_cor_x", cor_x, ex);
            check("wait_cor_z", cor_z, ez);
            check("wait_ready", req_ready, 0);
            check("wait_rsp_valid", rsp_valid, 0);
            if (w == delay) begin
                rx = dx; ry = dy; rz = dz; er = 1'b0;
                break;
            end
            if (w == TO - 2) er = 1'b1;
        end

        // Response phase with optional backpressure; fields must hold.
        for (int b = 0; b <= bp; b++) begin
            @(posedge clk); #1;
            rsp_ready = (b == bp);
            noise_core();
            @(negedge clk);
            check("rsp_valid", rsp_valid, 1);
            check("rsp_id", rsp_id, g);
            check("rsp_x", rsp_x, rx);
            check("rsp_y", rsp_y, ry);
            check("rsp_z", rsp_z, rz);
            check("rsp_err", rsp_err, er);
            check("rsp_cor_start", cor_start, 0);
            check("rsp_ready_req", req_ready, 0);
            check("rsp_cor_x", cor_x, 0);
        end
        exp_ptr = (g + 1) % N;

        // Back in IDLE with nobody asking.
        @(posedge clk); #1;
        req_valid = '0;
        cor_done  = 1'b0;
        rsp_ready = 1'b0;
        @(negedge clk);
        check("post_rsp_valid", rsp_valid, 0);
        check("post_busy", busy, 0);
        check("post_ready", req_ready, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N-1:0] m;
        int           r;
        int           d;
        rst = 1'b1;
        req_valid = '0;
        req_x = '0; req_y = '0; req_z = '0;
        rsp_ready = 1'b0;
        cor_done = 1'b0;
        cor_x_out = '0; cor_y_out = '0; cor_z_out = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_cor_start", cor_start, 0);
        check("rst_cor_x", cor_x, 0);
        check("rst_rsp_x", rsp_x, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_err", rsp_err, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_ptr = 0;

        // Round robin with everyone requesting: 0,1,2,3,0.
        for (int i = 0; i < 5; i++) begin
            randomize_ops();
            run_txn(4'hF, 1, 0, PW'($urandom), PW'($urandom), AW'($urandom));
        end

        // Single request from requester 2 with fixed data.
        randomize_ops();
        req_x[2*PW +: PW] = 16'd15563;
        req_y[2*PW +: PW] = 16'd1563;
        req_z[2*AW +: AW] = 16'd0;
        run_txn(4'b0100, 3, 0, 16'd25628, 16'd2574, 16'd0);

        // Backpressure for 10 cycles.
        randomize_ops();
        run_txn(4'b1011, 2, 10, PW'($urandom), PW'($urandom), AW'($urandom));

        // Timeout and done/timeout collision.
        randomize_ops();
        run_txn(4'b0110, -1, 1, PW'($urandom), PW'($urandom), AW'($urandom));
        randomize_ops();
        run_txn(4'b1001, TO - 2, 0, PW'($urandom), PW'($urandom), AW'($urandom));

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            randomize_ops();
            m = N'($urandom_range(1, (1 << N) - 1));
            r = $urandom_range(0, 9);
            if (r < 7)       d = $urandom_range(0, 8);
            else if (r == 7) d = -1;
            else if (r == 8) d = TO - 2;
            else             d = $urandom_range(0, TO - 2);
            run_txn(m, d, $urandom_range(0, 3), PW'($urandom), PW'($urandom), AW'($urandom));
        end

        // Move the pointer off zero, then reset mid-operation.
        randomize_ops();
        run_txn(4'b0001, 0, 0, PW'($urandom), PW'($urandom), AW'($urandom));
        @(posedge clk); #1;
        req_valid = 4'b1010;
        @(posedge clk); #1;
        req_valid = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        cor_done  = 1'b1;
        cor_x_out = 16'h1234;
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_cor_x", cor_x, 0);
        check("midrst_rsp_x", rsp_x, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("late_done_rsp_valid", rsp_valid, 0);
            check("late_done_busy", busy, 0);
        end
        @(posedge clk); #1;
        cor_done = 1'b0;
        exp_ptr = 0;
        randomize_ops();
        run_txn(4'hF, 2, 0, PW'($urandom), PW'($urandom), AW'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
